// File: rtl/interdevice_uart_tx_arbiter_pkg.sv
// Shared types for the inter-device UART transmit arbiter.
// Holds the frame state encoding, the bit-counter type and the UART clocking constants.
// Optional parity state appears only when INTERDEVICE_UART_PARITY_EN is defined.
package interdevice_uart_tx_arbiter_pkg;

  // Core clock cycles per UART clock enable, used by the baud generator.
  localparam int CPU_CLK_DIV = 4;

  // Fractional accumulator width used by the baud generator.
  typedef logic [15:0] uart_clk_precisision_t;

  // Bit counter wide enough for characters of up to 32 bits.
  localparam int BIT_CNT_W = 5;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Transmit frame sequencing; PARITY is only present in parity builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef INTERDEVICE_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/interdevice_uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after rr_ptr, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is used.
module interdevice_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Walk rr_ptr+1 .. rr_ptr+NUM_REQ modulo NUM_REQ; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/interdevice_uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte streams onto one UART TX line, packet-atomic, round-robin.
// Latency: byte accepted on an IDLE tick cycle; START bit begins the next cycle.
// Backpressure: req_ready pulses for one cycle per accepted byte; macro INTERDEVICE_UART_PARITY_EN adds even parity.
module interdevice_uart_tx_arbiter
  import interdevice_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            uart_tick_in,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            uart_tx,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam bit_cnt_t BIT_LAST = bit_cnt_t'(DATA_WIDTH - 1);

  arb_state_t            state;
  logic                  lock;
  logic [IDX_W-1:0]      rr_ptr;
  bit_cnt_t              bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  last_q;
  logic                  tx_q;
`ifdef INTERDEVICE_UART_PARITY_EN
  logic                  par_q;
`endif

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [NUM_REQ-1:0]    lock_onehot;
  logic                  load;
  logic [IDX_W-1:0]      load_idx;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  interdevice_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // While a packet lock is held only the owning requester may load.
  assign lock_onehot = NUM_REQ'(1) << grant_id;
  assign load        = (state == ST_IDLE) && uart_tick_in &&
                       (lock ? req_valid[grant_id] : arb_any);
  assign load_idx    = lock ? grant_id : arb_idx;
  assign load_data   = data_arr[load_idx];
  assign load_last   = req_last[load_idx];

  // Accept strobe is combinational so the byte is taken in the load cycle itself.
  always_comb begin
    req_ready = '0;
    if (load) req_ready = lock ? lock_onehot : arb_grant;
  end

  assign uart_tx = tx_q;
  assign busy    = (state != ST_IDLE) || lock;

  // Frame sequencer: every non-IDLE transition waits for a baud tick; tx is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      lock     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      bit_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
`ifdef INTERDEVICE_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state    <= ST_START;
            tx_q     <= 1'b0;
            grant_id <= load_idx;
            shreg    <= load_data;
            last_q   <= load_last;
            bit_cnt  <= '0;
`ifdef INTERDEVICE_UART_PARITY_EN
            par_q    <= ^load_data;
`endif
          end
        end
        ST_START: begin
          if (uart_tick_in) begin
            state   <= ST_DATA;
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (uart_tick_in) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef INTERDEVICE_UART_PARITY_EN
              state <= ST_PARITY;
              tx_q  <= par_q;
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef INTERDEVICE_UART_PARITY_EN
        ST_PARITY: begin
          if (uart_tick_in) begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (uart_tick_in) begin
            state <= ST_IDLE;
            if (last_q) begin
              lock   <= 1'b0;
              rr_ptr <= grant_id;
            end else begin
              lock   <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
